// File: rtl/uart_cmd_responder_if.sv
`default_nettype none
// ============================================================================
// uart_cmd_responder_if : byte bus between the command responder and its
// RX byte source, register file and TX FIFO.             Revision: 1.0
// ============================================================================
interface uart_cmd_responder_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
);
  logic [DATA_WIDTH-1:0] rx_p_data;
  logic                  rx_d_vld;
  logic [ADDR_WIDTH-1:0] rf_address;
  logic                  rf_wr_en;
  logic [DATA_WIDTH-1:0] rf_wr_data;
  logic                  rf_rd_en;
  logic [DATA_WIDTH-1:0] rf_rd_data;
  logic                  rf_rd_data_vld;
  logic                  fifo_full;
  logic [DATA_WIDTH-1:0] tx_p_data;
  logic                  tx_d_vld;
  logic                  busy;
  logic                  cmd_err;
  logic                  addr_err;
  logic                  tmo_err;
  logic                  ovr_err;

  // The responder itself
  modport master (
    input  rx_p_data, rx_d_vld, rf_rd_data, rf_rd_data_vld, fifo_full,
    output rf_address, rf_wr_en, rf_wr_data, rf_rd_en, tx_p_data, tx_d_vld,
           busy, cmd_err, addr_err, tmo_err, ovr_err
  );

  // Its surroundings (RX, register file, TX FIFO, status consumer)
  modport slave (
    output rx_p_data, rx_d_vld, rf_rd_data, rf_rd_data_vld, fifo_full,
    input  rf_address, rf_wr_en, rf_wr_data, rf_rd_en, tx_p_data, tx_d_vld,
           busy, cmd_err, addr_err, tmo_err, ovr_err
  );
endinterface
`default_nettype wire

// File: rtl/uart_cmd_responder.sv
`default_nettype none
// ============================================================================
// uart_cmd_responder : parses UART command frames into register-file strobes
// and returns read data as one byte to the TX FIFO.      Revision: 1.0
// ============================================================================
module uart_cmd_responder #(
  parameter int                    DATA_WIDTH = 8,
  parameter int                    ADDR_WIDTH = 4,
  parameter logic [DATA_WIDTH-1:0] WR_CMD     = 8'hAA,
  parameter logic [DATA_WIDTH-1:0] RD_CMD     = 8'hBB,
  parameter int                    TIMEOUT    = 1024
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  uart_cmd_responder_if.master bus_io
);

  localparam int                CNT_W    = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WR_ADDR = 3'd1,
    S_WR_DATA = 3'd2,
    S_RD_ADDR = 3'd3,
    S_RD_WAIT = 3'd4,
    S_TX_SEND = 3'd5
  } state_e;

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
  logic [DATA_WIDTH-1:0] rd_byte_q, rd_byte_d;
  logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
  logic                  wr_en_q, wr_en_d;
  logic                  rd_en_q, rd_en_d;
  logic                  tx_vld_q, tx_vld_d;
  logic                  busy_q, busy_d;
  logic                  cmd_err_q, cmd_err_d;
  logic                  addr_err_q, addr_err_d;
  logic                  tmo_err_q, tmo_err_d;
  logic                  ovr_err_q, ovr_err_d;

  logic                  w_addr_legal;
  logic                  w_expired;
  logic                  w_timed;

  assign w_addr_legal = ((bus_io.rx_p_data >> ADDR_WIDTH) == '0);
  assign w_expired    = (cnt_q == CNT_LAST);
  assign w_timed      = (state_q == S_WR_ADDR) || (state_q == S_WR_DATA) ||
                        (state_q == S_RD_ADDR) || (state_q == S_RD_WAIT);

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wr_data_d  = wr_data_q;
    rd_byte_d  = rd_byte_q;
    tx_data_d  = tx_data_q;
    wr_en_d    = 1'b0;
    rd_en_d    = 1'b0;
    tx_vld_d   = 1'b0;
    cmd_err_d  = 1'b0;
    addr_err_d = 1'b0;
    tmo_err_d  = 1'b0;
    ovr_err_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus_io.rx_d_vld) begin
          if (bus_io.rx_p_data == WR_CMD)      state_d = S_WR_ADDR;
          else if (bus_io.rx_p_data == RD_CMD) state_d = S_RD_ADDR;
          else                                 cmd_err_d = 1'b1;
        end
      end
      S_WR_ADDR: begin
        if (bus_io.rx_d_vld) begin
          if (w_addr_legal) begin
            addr_d  = bus_io.rx_p_data[ADDR_WIDTH-1:0];
            state_d = S_WR_DATA;
          end else begin
            addr_err_d = 1'b1;
            state_d    = S_IDLE;
          end
        end else if (w_expired) begin
          tmo_err_d = 1'b1;
          state_d   = S_IDLE;
        end
      end
      S_WR_DATA: begin
        if (bus_io.rx_d_vld) begin
          wr_data_d = bus_io.rx_p_data;
          wr_en_d   = 1'b1;
          state_d   = S_IDLE;
        end else if (w_expired) begin
          tmo_err_d = 1'b1;
          state_d   = S_IDLE;
        end
      end
      S_RD_ADDR: begin
        if (bus_io.rx_d_vld) begin
          if (w_addr_legal) begin
            addr_d  = bus_io.rx_p_data[ADDR_WIDTH-1:0];
            rd_en_d = 1'b1;
            state_d = S_RD_WAIT;
          end else begin
            addr_err_d = 1'b1;
            state_d    = S_IDLE;
          end
        end else if (w_expired) begin
          tmo_err_d = 1'b1;
          state_d   = S_IDLE;
        end
      end
      S_RD_WAIT: begin
        // A byte here is dropped; it does not count as progress for the timer
        ovr_err_d = bus_io.rx_d_vld;
        if (bus_io.rf_rd_data_vld) begin
          rd_byte_d = bus_io.rf_rd_data;
          state_d   = S_TX_SEND;
        end else if (w_expired) begin
          tmo_err_d = 1'b1;
          state_d   = S_IDLE;
        end
      end
      S_TX_SEND: begin
        ovr_err_d = bus_io.rx_d_vld;
        if (!bus_io.fifo_full) begin
          tx_data_d = rd_byte_q;
          tx_vld_d  = 1'b1;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Every accepted byte in a timed state also changes state, so a state
    // change alone is enough to restart the count.
    if ((state_d != state_q) || !w_timed) cnt_d = '0;
    else                                  cnt_d = cnt_q + 1'b1;

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      wr_data_q  <= '0;
      rd_byte_q  <= '0;
      tx_data_q  <= '0;
      wr_en_q    <= 1'b0;
      rd_en_q    <= 1'b0;
      tx_vld_q   <= 1'b0;
      busy_q     <= 1'b0;
      cmd_err_q  <= 1'b0;
      addr_err_q <= 1'b0;
      tmo_err_q  <= 1'b0;
      ovr_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      wr_data_q  <= wr_data_d;
      rd_byte_q  <= rd_byte_d;
      tx_data_q  <= tx_data_d;
      wr_en_q    <= wr_en_d;
      rd_en_q    <= rd_en_d;
      tx_vld_q   <= tx_vld_d;
      busy_q     <= busy_d;
      cmd_err_q  <= cmd_err_d;
      addr_err_q <= addr_err_d;
      tmo_err_q  <= tmo_err_d;
      ovr_err_q  <= ovr_err_d;
    end
  end

  assign bus_io.rf_address = addr_q;
  assign bus_io.rf_wr_en   = wr_en_q;
  assign bus_io.rf_wr_data = wr_data_q;
  assign bus_io.rf_rd_en   = rd_en_q;
  assign bus_io.tx_p_data  = tx_data_q;
  assign bus_io.tx_d_vld   = tx_vld_q;
  assign bus_io.busy       = busy_q;
  assign bus_io.cmd_err    = cmd_err_q;
  assign bus_io.addr_err   = addr_err_q;
  assign bus_io.tmo_err    = tmo_err_q;
  assign bus_io.ovr_err    = ovr_err_q;

endmodule
`default_nettype wire
